// File: rtl/mips16_pkg.sv
// mips16_pkg: shared definitions for the 16-bit MIPS-like instruction format.
// The decoder and the encoder/loader both import this package, so the field
// positions below are the single place the instruction layout is defined.
package mips16_pkg;

   localparam int INSTR_W = 16;
   localparam int FIELD_W = 4;
   localparam int JUMP_W  = 12;

   // Opcode values (word[15:12]); 8..15 are unassigned and therefore illegal
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_ADDI = 4'd2;
   localparam logic [3:0] OP_LW   = 4'd3;
   localparam logic [3:0] OP_SW   = 4'd4;
   localparam logic [3:0] OP_JUMP = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_OR   = 4'd7;

   // Bit positions of the nibble fields inside the instruction word
   localparam int OP_LSB   = 12;
   localparam int F1_LSB   = 8;
   localparam int F2_LSB   = 4;
   localparam int F3_LSB   = 0;
   localparam int JUMP_LSB = 0;

   // Per-field description of one instruction as delivered by the host
   typedef struct packed {
      logic [3:0]        opcode;
      logic [3:0]        rd;
      logic [3:0]        rs;
      logic [3:0]        rt;
      logic [3:0]        im;
      logic [JUMP_W-1:0] jump;
   } instr_fields_t;

   // Only the lower eight opcodes carry a defined instruction
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op[3] == 1'b0);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: purely combinational field-to-word packer. Places each field
// exactly where the decoder expects it and flags opcodes that have no
// defined encoding, so the loader can drop them.
module instr_pack
   import mips16_pkg::*;
(
   input  instr_fields_t        fields,
   output logic [INSTR_W-1:0]   word,
   output logic                 illegal
);

   // Select the field layout from the opcode; unused fields are simply not placed
   always_comb begin
      word    = '0;
      illegal = !op_is_legal(fields.opcode);
      word[OP_LSB +: FIELD_W] = fields.opcode;
      case (fields.opcode)
         OP_ADD, OP_SUB, OP_XOR, OP_OR: begin
            word[F1_LSB +: FIELD_W] = fields.rd;
            word[F2_LSB +: FIELD_W] = fields.rs;
            word[F3_LSB +: FIELD_W] = fields.rt;
         end
         OP_ADDI, OP_LW: begin
            word[F1_LSB +: FIELD_W] = fields.rd;
            word[F2_LSB +: FIELD_W] = fields.rs;
            word[F3_LSB +: FIELD_W] = fields.im;
         end
         OP_SW: begin
            word[F1_LSB +: FIELD_W] = fields.rt;
            word[F2_LSB +: FIELD_W] = fields.rs;
            word[F3_LSB +: FIELD_W] = fields.im;
         end
         OP_JUMP: begin
            word[JUMP_LSB +: JUMP_W] = fields.jump;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: accepts per-field instruction beats over valid/ready,
// packs them into 16-bit words and writes them into instruction memory at
// consecutive addresses starting from BASE_ADDR.
// Optional macro NOP_PAD_EN: after the final beat, fill every remaining
// address up to the top of memory with 16'h0000 before finishing.
module instr_encoder_loader
   import mips16_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_opcode,
   input  logic [3:0]          in_rd,
   input  logic [3:0]          in_rs,
   input  logic [3:0]          in_rt,
   input  logic [3:0]          in_im,
   input  logic [11:0]         in_jump,
   input  logic                in_last,
   output logic                imem_we,
   output logic [ADDR_W-1:0]   imem_addr,
   output logic [15:0]         imem_wdata,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [ADDR_W:0]     count
);

   localparam logic [ADDR_W-1:0] BASE_PTR = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] TOP_PTR  = {ADDR_W{1'b1}};

`ifdef NOP_PAD_EN
   typedef enum logic [1:0] {IDLE, LOAD, PAD, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;
`endif

   state_t               state;
   logic [ADDR_W-1:0]    ptr;
   instr_fields_t        fields;
   logic [INSTR_W-1:0]   packed_word;
   logic                 op_illegal;
   logic                 accept;

   assign fields = '{opcode: in_opcode, rd: in_rd, rs: in_rs, rt: in_rt,
                     im: in_im, jump: in_jump};
   assign accept = in_valid && in_ready;

   instr_pack u_pack (
      .fields  (fields),
      .word    (packed_word),
      .illegal (op_illegal)
   );

   // Session FSM: ptr always holds the next unwritten address; all outputs registered
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         ptr        <= BASE_PTR;
         in_ready   <= 1'b0;
         imem_we    <= 1'b0;
         imem_addr  <= BASE_PTR;
         imem_wdata <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
         count      <= '0;
      end else begin
         imem_we <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  ptr      <= BASE_PTR;
                  count    <= '0;
                  err      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (accept) begin
                  if (op_illegal) begin
                     err <= 1'b1;
                  end else begin
                     imem_we    <= 1'b1;
                     imem_addr  <= ptr;
                     imem_wdata <= packed_word;
                     count      <= count + 1'b1;
                     if (ptr != TOP_PTR) begin
                        ptr <= ptr + 1'b1;
                     end
                  end
                  if (!op_illegal && ptr == TOP_PTR) begin
                     in_ready <= 1'b0;
                     state    <= DONE;
                     done     <= 1'b1;
                     if (!in_last) begin
                        err <= 1'b1;
                     end
                  end else if (in_last) begin
                     in_ready <= 1'b0;
`ifdef NOP_PAD_EN
                     state    <= PAD;
`else
                     state    <= DONE;
                     done     <= 1'b1;
`endif
                  end
               end
            end
`ifdef NOP_PAD_EN
            PAD: begin
               imem_we    <= 1'b1;
               imem_addr  <= ptr;
               imem_wdata <= '0;
               count      <= count + 1'b1;
               if (ptr == TOP_PTR) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
`endif
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed self-checking bench. A default-size
// instance covers encoding, back-to-back loads, illegal opcodes and reset;
// a tiny instance covers memory-full overflow (and padding with NOP_PAD_EN).
module tb_instr_encoder_loader;

`ifdef NOP_PAD_EN
   localparam int SMALL_W = 3;
`else
   localparam int SMALL_W = 2;
`endif
   localparam int SMALL_DEPTH = 2 ** SMALL_W;
   localparam int MAIN_DEPTH  = 256;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_opcode;
   logic [3:0]  in_rd;
   logic [3:0]  in_rs;
   logic [3:0]  in_rt;
   logic [3:0]  in_im;
   logic [11:0] in_jump;
   logic        in_last;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        busy;
   logic        done;
   logic        err;
   logic [8:0]  count;

   logic               s_start;
   logic               s_valid;
   logic               s_ready;
   logic               s_we;
   logic [SMALL_W-1:0] s_addr;
   logic [15:0]        s_wdata;
   logic               s_busy;
   logic               s_done;
   logic               s_err;
   logic [SMALL_W:0]   s_count;

   int checks = 0;
   int errors = 0;

   instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
      .in_rt(in_rt), .in_im(in_im), .in_jump(in_jump), .in_last(in_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   instr_encoder_loader #(.ADDR_W(SMALL_W), .BASE_ADDR(0)) u_small (
      .clk(clk), .rst_n(rst_n), .start(s_start), .in_valid(s_valid),
      .in_ready(s_ready), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs(in_rs),
      .in_rt(in_rt), .in_im(in_im), .in_jump(in_jump), .in_last(in_last),
      .imem_we(s_we), .imem_addr(s_addr), .imem_wdata(s_wdata),
      .busy(s_busy), .done(s_done), .err(s_err), .count(s_count)
   );

   // 100 MHz free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int mainCount(input int written);
`ifdef NOP_PAD_EN
      return MAIN_DEPTH;
`else
      return written;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] op, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [3:0] rt,
                                input logic [3:0] im, input logic [11:0] jump,
                                input logic last);
      in_opcode = op;
      in_rd     = rd;
      in_rs     = rs;
      in_rt     = rt;
      in_im     = im;
      in_jump   = jump;
      in_last   = last;
   endtask

   task automatic sendMain(input string tag, input logic exp_we,
                           input logic [7:0] exp_addr, input logic [15:0] exp_data);
      in_valid = 1'b1;
      checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
      tick();
      checkOutput({tag, "_we"}, 32'(imem_we), 32'(exp_we));
      if (exp_we) begin
         checkOutput({tag, "_addr"}, 32'(imem_addr), 32'(exp_addr));
         checkOutput({tag, "_data"}, 32'(imem_wdata), 32'(exp_data));
      end
   endtask

   task automatic startMain(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
      checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, "_err"}, 32'(err), 32'd0);
   endtask

   task automatic waitDoneMain(input string tag, input int exp_count, input logic exp_err);
      int n = 0;
      while (done !== 1'b1 && n < 600) begin
         tick();
         n++;
      end
      checkOutput({tag, "_done"}, 32'(done), 32'd1);
      checkOutput({tag, "_count"}, 32'(count), 32'(exp_count));
      checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
      checkOutput({tag, "_rdy_low"}, 32'(in_ready), 32'd0);
      tick();
      checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
      checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   // Directed sequence of load sessions with hand-computed expected words
   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      in_valid = 1'b0;
      s_start  = 1'b0;
      s_valid  = 1'b0;
      applyStimulus(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 12'h000, 1'b0);
      tick();
      tick();
      checkOutput("rst_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_we", 32'(imem_we), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_err", 32'(err), 32'd0);
      checkOutput("rst_addr", 32'(imem_addr), 32'd0);
      checkOutput("rst_wdata", 32'(imem_wdata), 32'd0);
      checkOutput("rst_count", 32'(count), 32'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("idle_ready", 32'(in_ready), 32'd0);

      // Single ADD r3,r1,r2
      startMain("t1_start");
      applyStimulus(4'h0, 4'h3, 4'h1, 4'h2, 4'hA, 12'hFFF, 1'b1);
      sendMain("t1_add", 1'b1, 8'd0, 16'h0312);
      in_valid = 1'b0;
      waitDoneMain("t1_end", mainCount(1), 1'b0);

      // SW / JUMP / LW back to back, with a stray start that must be ignored
      startMain("t2_start");
      applyStimulus(4'h4, 4'hF, 4'h2, 4'h5, 4'h4, 12'hFFF, 1'b0);
      sendMain("t2_sw", 1'b1, 8'd0, 16'h4524);
      start = 1'b1;
      applyStimulus(4'h5, 4'h1, 4'h2, 4'h3, 4'h4, 12'h0AB, 1'b0);
      sendMain("t2_jump", 1'b1, 8'd1, 16'h50AB);
      start = 1'b0;
      applyStimulus(4'h3, 4'h7, 4'h1, 4'h9, 4'hF, 12'h123, 1'b1);
      sendMain("t2_lw", 1'b1, 8'd2, 16'h371F);
      in_valid = 1'b0;
      waitDoneMain("t2_end", mainCount(3), 1'b0);

      // Illegal opcode is consumed without a write and sets sticky err
      startMain("t3_start");
      applyStimulus(4'h9, 4'h1, 4'h2, 4'h3, 4'h4, 12'h567, 1'b0);
      sendMain("t3_illegal", 1'b0, 8'd0, 16'h0000);
      checkOutput("t3_err_set", 32'(err), 32'd1);
      applyStimulus(4'h2, 4'h1, 4'h0, 4'h7, 4'h3, 12'h000, 1'b1);
      sendMain("t3_addi", 1'b1, 8'd0, 16'h2103);
      in_valid = 1'b0;
      waitDoneMain("t3_end", mainCount(1), 1'b1);
      tick();
      checkOutput("t3_err_sticky", 32'(err), 32'd1);
      startMain("t4_start");

      // Reset while a beat is being accepted: that write must never appear
      applyStimulus(4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 12'h000, 1'b0);
      sendMain("t4_a", 1'b1, 8'd0, 16'h0111);
      applyStimulus(4'h1, 4'h2, 4'h2, 4'h2, 4'h0, 12'h000, 1'b0);
      sendMain("t4_b", 1'b1, 8'd1, 16'h1222);
      applyStimulus(4'h6, 4'h3, 4'h3, 4'h3, 4'h0, 12'h000, 1'b0);
      rst_n = 1'b0;
      tick();
      in_valid = 1'b0;
      checkOutput("t4_rst_we", 32'(imem_we), 32'd0);
      checkOutput("t4_rst_addr", 32'(imem_addr), 32'd0);
      checkOutput("t4_rst_wdata", 32'(imem_wdata), 32'd0);
      checkOutput("t4_rst_count", 32'(count), 32'd0);
      checkOutput("t4_rst_busy", 32'(busy), 32'd0);
      checkOutput("t4_rst_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b1;
      tick();
      checkOutput("t4_post_we", 32'(imem_we), 32'd0);
      startMain("t4_restart");
      applyStimulus(4'h7, 4'h1, 4'h2, 4'h3, 4'h0, 12'h000, 1'b1);
      sendMain("t4_or", 1'b1, 8'd0, 16'h7123);
      in_valid = 1'b0;
      waitDoneMain("t4_end", mainCount(1), 1'b0);

      // Tiny memory filled without a last beat: overflow ends the session
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      for (int k = 0; k < SMALL_DEPTH; k++) begin
         applyStimulus(4'h2, 4'(k), 4'h0, 4'h0, 4'(k), 12'h000, 1'b0);
         s_valid = 1'b1;
         checkOutput($sformatf("t5_ready%0d", k), 32'(s_ready), 32'd1);
         tick();
         checkOutput($sformatf("t5_we%0d", k), 32'(s_we), 32'd1);
         checkOutput($sformatf("t5_addr%0d", k), 32'(s_addr), 32'(k));
         checkOutput($sformatf("t5_data%0d", k), 32'(s_wdata),
                     32'h2000 | 32'(k << 8) | 32'(k));
      end
      applyStimulus(4'h2, 4'hF, 4'h0, 4'h0, 4'hF, 12'h000, 1'b0);
      checkOutput("t5_ready_low", 32'(s_ready), 32'd0);
      checkOutput("t5_done", 32'(s_done), 32'd1);
      checkOutput("t5_err", 32'(s_err), 32'd1);
      checkOutput("t5_count", 32'(s_count), 32'(SMALL_DEPTH));
      tick();
      s_valid = 1'b0;
      checkOutput("t5_no_extra_we", 32'(s_we), 32'd0);
      checkOutput("t5_done_pulse", 32'(s_done), 32'd0);
      checkOutput("t5_idle", 32'(s_busy), 32'd0);

`ifdef NOP_PAD_EN
      // Two real words, then zero padding up to the top address
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      checkOutput("t6_err_clr", 32'(s_err), 32'd0);
      applyStimulus(4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 12'h000, 1'b0);
      s_valid = 1'b1;
      tick();
      checkOutput("t6_w0", 32'(s_wdata), 32'h0111);
      applyStimulus(4'h3, 4'h2, 4'h3, 4'h0, 4'h4, 12'h000, 1'b1);
      tick();
      s_valid = 1'b0;
      checkOutput("t6_w1", 32'(s_wdata), 32'h3234);
      checkOutput("t6_a1", 32'(s_addr), 32'd1);
      checkOutput("t6_ready_low", 32'(s_ready), 32'd0);
      for (int a = 2; a < SMALL_DEPTH; a++) begin
         tick();
         checkOutput($sformatf("t6_pad_we%0d", a), 32'(s_we), 32'd1);
         checkOutput($sformatf("t6_pad_addr%0d", a), 32'(s_addr), 32'(a));
         checkOutput($sformatf("t6_pad_data%0d", a), 32'(s_wdata), 32'd0);
      end
      checkOutput("t6_done", 32'(s_done), 32'd1);
      checkOutput("t6_count", 32'(s_count), 32'(SMALL_DEPTH));
      checkOutput("t6_err", 32'(s_err), 32'd0);
      tick();
      checkOutput("t6_we_stop", 32'(s_we), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Sequential inverse of the instruction decoder: accepts per-field instruction descriptions (opcode, rd, rs, rt, im, jump) over a valid/ready stream.
- Packs each into the 16-bit instruction word exactly as the decoder unpacks it, and writes it into instruction memory at consecutive addresses.
- Sits between the testbench/boot host and the instruction memory; used to load programs before the core runs.

Parameters:
ADDR_W, 8, instruction-memory address width; depth = 2**ADDR_W words
BASE_ADDR, 0, first write address of a load session (must be < 2**ADDR_W)

Ports:
clk  in  1  clock, all logic rising-edge
rst_n  in  1  synchronous active-low reset
start  in  1  pulse in IDLE begins a load session; ignored elsewhere
in_valid  in  1  field beat valid
in_ready  out  1  beat accepted when in_valid&&in_ready
in_opcode  in  4  opcode
in_rd  in  4  destination reg
in_rs  in  4  source/base reg
in_rt  in  4  second source / SW data reg
in_im  in  4  immediate/offset
in_jump  in  12  jump target
in_last  in  1  final beat of program
imem_we  out  1  memory write strobe
imem_addr  out  ADDR_W  write address
imem_wdata  out  16  encoded instruction
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at session end
err  out  1  sticky error, cleared by next accepted start
count  out  ADDR_W+1  words written this session

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; in_ready, imem_we, busy, done, err = 0; imem_addr=BASE_ADDR; imem_wdata=0; count=0.
- States: IDLE, LOAD, DONE (+PAD with macro).
- IDLE: in_ready=0. start -> LOAD; addr pointer=BASE_ADDR, count=0, err=0.
- LOAD: in_ready=1. Each accepted beat with a legal opcode produces, next cycle, imem_we=1 with encoded word and current pointer; pointer++, count++. Latency 1 cycle, throughput 1 beat/cycle; imem_* registered.
- Encoding, word[15:12]=opcode:
  - 0,1,6,7 (ADD,SUB,XOR,OR): [11:8]=rd, [7:4]=rs, [3:0]=rt.
  - 2,3 (ADDI,LW): [11:8]=rd, [7:4]=rs, [3:0]=im.
  - 4 (SW): [11:8]=rt, [7:4]=rs, [3:0]=im.
  - 5 (JUMP): [11:0]=jump.
  - Unused fields ignored.
- Illegal opcode 8..15: beat consumed, no write, pointer unchanged, err=1; session continues. If in_last set on it, session still ends.
- End: accepted beat with in_last -> DONE (after its write issues). Write to address 2**ADDR_W-1 without in_last -> DONE with err=1 (overflow); in_ready drops the cycle after that beat is accepted.
- DONE: done=1 for exactly one cycle, in_ready=0, -> IDLE. busy=0 in IDLE only.
- Pointer never wraps within a session.
- start while busy: ignored.
- Reset mid-session: any pending write is discarded; no imem_we the cycle after reset.

Optional Feature:
NOP_PAD_EN:
- Defined: after the last beat, FSM enters PAD with in_ready=0. Writes 16'h0000 (ADD r0,r0,r0) to every remaining address up to 2**ADDR_W-1, one per cycle; count includes pads; then DONE.
- Skip PAD if the last write already hit the top address.
- Undefined: no PAD state; LOAD -> DONE directly.

Decomposition:
- Shared package mips16_pkg: opcode localparams (OP_ADD=0 .. OP_OR=7), instruction width 16, field bit positions; shared with the decoder.
- One natural sub-module, instr_pack: pure combinational field->word packer plus illegal-opcode flag; FSM, pointer and handshake stay in the top.

Test Plan:
- start; beat ADD rd=3 rs=1 rt=2 last=1 -> next cycle imem_we=1, addr=0, wdata=16'h0312; done pulse; count=1; err=0.
- Beats SW rt=5 rs=2 im=4; JUMP jump=12'h0AB; LW rd=7 rs=1 im=F last -> writes 16'h4524 @0, 16'h50AB @1, 16'h371F @2, back-to-back cycles.
- Beat opcode=9, then ADDI rd=1 rs=0 im=3 last -> single write 16'h2103 @0; err=1 until next start.
- ADDR_W=2, 5 beats no last -> 4 writes @0..3, in_ready low after 4th, done with err=1, count=4.
- rst_n=0 the cycle after a beat is accepted -> no imem_we follows; all outputs at reset values; new start begins at BASE_ADDR.
- NOP_PAD_EN, ADDR_W=3, 2 beats (last on 2nd) -> writes @0,1, then 16'h0000 @2..7; done after addr 7; count=8.
